led_afterglow_pwm: RTL

//   Downstream consumer of the rotating LED pattern produced by the LED shifter stage.

---
 rtl/led_afterglow_pwm_pkg.sv | 18 +
 rtl/led_fade_channel.sv | 57 +++++
 rtl/led_afterglow_pwm.sv | 67 ++++++
 3 files changed

// File: rtl/led_afterglow_pwm_pkg.sv
// Shared helpers for the LED afterglow PWM stage: level ceiling, divider width
// and the saturating brightness decrement.
package led_afterglow_pwm_pkg;

  function automatic int lvl_max(input int pwm_bits);
    return (1 << pwm_bits) - 1;
  endfunction

  // A divide-by-1 still needs a one-bit counter that never leaves 0.
  function automatic int div_width(input int decay_div);
    return (decay_div <= 1) ? 1 : $clog2(decay_div);
  endfunction

  function automatic int sat_sub(input int level, input int step);
    return (level > step) ? level - step : 0;
  endfunction

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: brightness level with linear decay, a shadow copy that is
// only refreshed at the period boundary, and the registered PWM compare.
module led_fade_channel
  import led_afterglow_pwm_pkg::*;
#(
  parameter int PWM_BITS   = 8,
  parameter int DECAY_STEP = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pat_bit,
  input  logic                decay_tick,
  input  logic                load_shadow,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                bypass,
  output logic                led
);

  localparam logic [PWM_BITS-1:0] LVL_MAX = PWM_BITS'(lvl_max(PWM_BITS));

  logic [PWM_BITS-1:0] level_reg;
  logic [PWM_BITS-1:0] level_next;
  logic [PWM_BITS-1:0] shadow_reg;
  logic                led_next;

  // A lit bit always wins over a decay tick landing in the same cycle.
  always_comb begin
    level_next = level_reg;
    if (pat_bit) begin
      level_next = LVL_MAX;
    end else if (decay_tick) begin
      level_next = PWM_BITS'(sat_sub(int'(level_reg), DECAY_STEP));
    end
  end

  always_comb begin
    led_next = pat_bit;
    if (!bypass) begin
      led_next = pat_bit | (shadow_reg == LVL_MAX) | (shadow_reg > pwm_cnt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_reg  <= '0;
      shadow_reg <= '0;
      led        <= 1'b0;
    end else begin
      level_reg <= level_next;
      if (load_shadow) begin
        shadow_reg <= level_reg;
      end
      led <= led_next;
    end
  end

endmodule

// File: rtl/led_afterglow_pwm.sv
// Final LED pin drive: registers the shifter pattern, runs the shared PWM and
// decay timebases, and fans out to one fade channel per LED.
module led_afterglow_pwm
  import led_afterglow_pwm_pkg::*;
#(
  parameter int LED_COUNT  = 8,
  parameter int PWM_BITS   = 8,
  parameter int DECAY_DIV  = 4096,
  parameter int DECAY_STEP = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [LED_COUNT-1:0] pattern_in,
  input  logic                 bypass,
  output logic [LED_COUNT-1:0] led_out,
  output logic                 period_start
);

  localparam logic [PWM_BITS-1:0] LVL_MAX  = PWM_BITS'(lvl_max(PWM_BITS));
  localparam int                  DIV_W    = div_width(DECAY_DIV);
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(DECAY_DIV - 1);

  logic [LED_COUNT-1:0] pat_q;
  logic [PWM_BITS-1:0]  pwm_cnt_reg;
  logic [DIV_W-1:0]     div_cnt_reg;
  logic [DIV_W-1:0]     div_cnt_next;
  logic                 period_start_reg;
  logic                 decay_tick;
  logic                 load_shadow;

  assign decay_tick   = (div_cnt_reg == DIV_LAST);
  assign load_shadow  = (pwm_cnt_reg == LVL_MAX);
  assign div_cnt_next = decay_tick ? '0 : div_cnt_reg + DIV_W'(1);
  assign period_start = period_start_reg;

  // pwm_cnt wraps naturally at LVL_MAX; period_start marks the cycle it reads 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q            <= '0;
      pwm_cnt_reg      <= '0;
      div_cnt_reg      <= '0;
      period_start_reg <= 1'b0;
    end else begin
      pat_q            <= pattern_in;
      pwm_cnt_reg      <= pwm_cnt_reg + PWM_BITS'(1);
      div_cnt_reg      <= div_cnt_next;
      period_start_reg <= load_shadow;
    end
  end

  for (genvar gi = 0; gi < LED_COUNT; gi++) begin : g_ch
    led_fade_channel #(
      .PWM_BITS   (PWM_BITS),
      .DECAY_STEP (DECAY_STEP)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .pat_bit     (pat_q[gi]),
      .decay_tick  (decay_tick),
      .load_shadow (load_shadow),
      .pwm_cnt     (pwm_cnt_reg),
      .bypass      (bypass),
      .led         (led_out[gi])
    );
  end

endmodule
